instr_fetch: RTL and testbench

Instruction-fetch front end for the MIPS datapath, and the initiator on the instruction-memory port. It generates sequential word addresses from a PC register, requests words over a req/ack port, and buffers up to two {pc, instruction} pairs in a prefetch buffer. It hands instructions to decode over a valid/ready handshake and supports a branch/jump redirect that flushes in-flight work.

---
 rtl/instr_fetch_if.sv | 41 ++++
 rtl/instr_fetch.sv | 140 ++++++++++++++
 tb/tb_instr_fetch.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-fetch port bundle: instruction-memory request/ack side,
// branch/jump redirect, and the valid/ready handshake toward decode.
// The fetch unit is the master; memory/decode/branch logic form the slave side.
interface instr_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_instruction;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instruction;
   logic [31:0] out_pc;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_instruction,
      input  redirect,
      input  redirect_pc,
      output out_valid,
      input  out_ready,
      output out_instruction,
      output out_pc
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_instruction,
      output redirect,
      output redirect_pc,
      input  out_valid,
      output out_ready,
      input  out_instruction,
      input  out_pc
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction-fetch front end: sequential PC generation, single-outstanding
// request to instruction memory, 2-entry {pc, instr} prefetch buffer, and
// redirect that flushes buffered and in-flight work.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no request; buffer full (or just reset), waiting for a free slot
// REQ   | request for fetch_pc on the memory port, waiting for ack
// DROP  | request abandoned by a redirect; hold stale address until ack
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   instr_fetch_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] fetch_pc;
   logic [31:0] stale_addr;
   logic [1:0]  count;
   logic [1:0]  count_next;

   // head is the entry presented to decode; tail is the second slot
   logic [31:0] head_pc;
   logic [31:0] head_instr;
   logic [31:0] tail_pc;
   logic [31:0] tail_instr;

   logic        pop;
   logic        push;
   logic        push_to_tail;

   // Handshake events and buffer occupancy; redirect cancels both pop and push
   always_comb begin
      pop          = 1'b0;
      push         = 1'b0;
      count_next   = count;
      push_to_tail = 1'b0;
      pop  = (count != 2'd0) && bus.out_ready && !bus.redirect;
      push = (state == REQ) && bus.imem_ack && !bus.redirect;
      if (bus.redirect) begin
         count_next = 2'd0;
      end else begin
         count_next = count + {1'b0, push} - {1'b0, pop};
      end
      // after an optional shift, the new word lands in the first free slot
      push_to_tail = pop ? (count == 2'd2) : (count == 2'd1);
   end

   // Next-state logic; redirect wins in every state
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.redirect || (count_next < 2'd2)) begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (bus.redirect) begin
               state_next = bus.imem_ack ? REQ : DROP;
            end else if (bus.imem_ack) begin
               state_next = (count_next < 2'd2) ? REQ : IDLE;
            end
         end
         DROP: begin
            // stale data is discarded on ack whether or not another redirect arrives
            if (bus.imem_ack) begin
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Fetch PC, stale request address, occupancy and buffer storage
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc   <= RESET_PC;
         stale_addr <= RESET_PC;
         count      <= 2'd0;
         head_pc    <= 32'h0;
         head_instr <= 32'h0;
         tail_pc    <= 32'h0;
         tail_instr <= 32'h0;
      end else if (bus.redirect) begin
         count    <= 2'd0;
         fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
         // the in-flight address must stay on the port until memory acks it;
         // a redirect while already in DROP keeps the original stale address
         if ((state == REQ) && !bus.imem_ack) begin
            stale_addr <= fetch_pc;
         end
      end else begin
         count <= count_next;
         if (push) begin
            fetch_pc <= fetch_pc + 32'd4;
         end
         if (pop) begin
            head_pc    <= tail_pc;
            head_instr <= tail_instr;
         end
         // later assignment overrides the shift when the push lands in the head
         if (push) begin
            if (push_to_tail) begin
               tail_pc    <= fetch_pc;
               tail_instr <= bus.imem_instruction;
            end else begin
               head_pc    <= fetch_pc;
               head_instr <= bus.imem_instruction;
            end
         end
      end
   end

   assign bus.imem_req        = (state == REQ) || (state == DROP);
   assign bus.imem_addr       = (state == DROP) ? stale_addr : fetch_pc;
   assign bus.out_valid       = (count != 2'd0);
   assign bus.out_pc          = head_pc;
   assign bus.out_instruction = head_instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: two instances (RESET_PC 0 and FFFF_FFF8)
// each with a memory model returning mem[i]=i after a programmable ack delay.
module tb_instr_fetch;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   instr_fetch_if ifa();
   instr_fetch_if ifb();

   instr_fetch #(.RESET_PC(32'h0000_0000)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   instr_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // memory model A: ack after lat_a waiting cycles of an asserted request
   int lat_a;
   int wcnt_a;
   assign ifa.imem_ack         = ifa.imem_req && (wcnt_a == lat_a);
   assign ifa.imem_instruction = {2'b00, ifa.imem_addr[31:2]};

   // memory model A wait counter
   always @(posedge clk) begin
      if (reset) wcnt_a <= 0;
      else if (ifa.imem_req && ifa.imem_ack) wcnt_a <= 0;
      else if (ifa.imem_req) wcnt_a <= wcnt_a + 1;
   end

   // memory model B: zero-latency, ack tied to req
   assign ifb.imem_ack         = ifb.imem_req;
   assign ifb.imem_instruction = {2'b00, ifb.imem_addr[31:2]};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // hold reset two cycles, release it; returns in cycle 0
   task automatic do_reset(input int lat, input logic ready);
      reset         = 1'b1;
      lat_a         = lat;
      ifa.out_ready = ready;
      ifa.redirect  = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] pb;
      errors          = 0;
      checks          = 0;
      reset           = 1'b1;
      lat_a           = 0;
      ifa.out_ready   = 1'b1;
      ifa.redirect    = 1'b0;
      ifa.redirect_pc = 32'h0;
      ifb.out_ready   = 1'b1;
      ifb.redirect    = 1'b0;
      ifb.redirect_pc = 32'h0;

      // ---- streaming with zero-latency memory
      do_reset(0, 1'b1);
      chk("rst_req_a",   {31'd0, ifa.imem_req},  32'd0);
      chk("rst_addr_a",  ifa.imem_addr,          32'h0);
      chk("rst_valid_a", {31'd0, ifa.out_valid}, 32'd0);
      chk("rst_pc_a",    ifa.out_pc,             32'h0);
      chk("rst_ins_a",   ifa.out_instruction,    32'h0);
      chk("rst_addr_b",  ifb.imem_addr,          32'hFFFF_FFF8);
      chk("rst_req_b",   {31'd0, ifb.imem_req},  32'd0);
      step(); // cycle 1
      chk("c1_req",   {31'd0, ifa.imem_req},  32'd1);
      chk("c1_addr",  ifa.imem_addr,          32'h0);
      chk("c1_valid", {31'd0, ifa.out_valid}, 32'd0);
      step(); // cycle 2
      for (int i = 0; i < 5; i++) begin
         pb = 32'hFFFF_FFF8 + 32'(4 * i);
         chk("stream_valid", {31'd0, ifa.out_valid}, 32'd1);
         chk("stream_pc",    ifa.out_pc,             32'(4 * i));
         chk("stream_ins",   ifa.out_instruction,    32'(i));
         chk("wrap_pc_b",    ifb.out_pc,             pb);
         chk("wrap_ins_b",   ifb.out_instruction,    {2'b00, pb[31:2]});
         if (i < 4) step();
      end
      // mid-stream reset: outputs return to reset values next cycle
      reset = 1'b1;
      step();
      chk("mrst_req_a",   {31'd0, ifa.imem_req},  32'd0);
      chk("mrst_valid_a", {31'd0, ifa.out_valid}, 32'd0);
      chk("mrst_pc_a",    ifa.out_pc,             32'h0);
      chk("mrst_req_b",   {31'd0, ifb.imem_req},  32'd0);
      chk("mrst_addr_b",  ifb.imem_addr,          32'hFFFF_FFF8);
      chk("mrst_valid_b", {31'd0, ifb.out_valid}, 32'd0);
      chk("mrst_pc_b",    ifb.out_pc,             32'h0);
      chk("mrst_ins_b",   ifb.out_instruction,    32'h0);

      // ---- back-pressure
      do_reset(0, 1'b0);
      step(); // c1
      step(); // c2
      chk("bp_c2_pc",   ifa.out_pc,            32'h0);
      chk("bp_c2_addr", ifa.imem_addr,         32'h4);
      step(); // c3
      chk("bp_c3_req",  {31'd0, ifa.imem_req}, 32'd0);
      chk("bp_c3_pc",   ifa.out_pc,            32'h0);
      step(); // c4
      chk("bp_c4_req",  {31'd0, ifa.imem_req}, 32'd0);
      chk("bp_c4_pc",   ifa.out_pc,            32'h0);
      chk("bp_c4_ins",  ifa.out_instruction,   32'h0);
      ifa.out_ready = 1'b1;
      step(); // c5
      chk("bp_c5_pc",   ifa.out_pc,            32'h4);
      chk("bp_c5_ins",  ifa.out_instruction,   32'h1);
      chk("bp_c5_addr", ifa.imem_addr,         32'h8);
      step(); // c6
      chk("bp_c6_valid", {31'd0, ifa.out_valid}, 32'd1);
      chk("bp_c6_pc",   ifa.out_pc,            32'h8);
      step(); // c7
      chk("bp_c7_pc",   ifa.out_pc,            32'hC);

      // ---- 3-cycle memory latency, then redirect during a pending request
      do_reset(3, 1'b1);
      for (int c = 1; c <= 4; c++) begin
         step();
         chk("lat_req0",   {31'd0, ifa.imem_req},  32'd1);
         chk("lat_addr0",  ifa.imem_addr,          32'h0);
         chk("lat_valid0", {31'd0, ifa.out_valid}, 32'd0);
      end
      step(); // c5
      chk("lat_c5_pc",    ifa.out_pc,             32'h0);
      chk("lat_c5_valid", {31'd0, ifa.out_valid}, 32'd1);
      chk("lat_c5_addr",  ifa.imem_addr,          32'h4);
      for (int c = 6; c <= 8; c++) begin
         step();
         chk("lat_valid1", {31'd0, ifa.out_valid}, 32'd0);
         chk("lat_addr1",  ifa.imem_addr,          32'h4);
      end
      step(); // c9
      chk("lat_c9_pc",   ifa.out_pc,          32'h4);
      chk("lat_c9_ins",  ifa.out_instruction, 32'h1);
      chk("lat_c9_addr", ifa.imem_addr,       32'h8);
      step(); // c10
      ifa.redirect    = 1'b1;
      ifa.redirect_pc = 32'h0000_0102;
      step(); // c11
      ifa.redirect = 1'b0;
      chk("drop_c11_req",   {31'd0, ifa.imem_req},  32'd1);
      chk("drop_c11_addr",  ifa.imem_addr,          32'h8);
      chk("drop_c11_valid", {31'd0, ifa.out_valid}, 32'd0);
      step(); // c12
      chk("drop_c12_addr",  ifa.imem_addr,          32'h8);
      step(); // c13
      chk("drop_c13_addr",  ifa.imem_addr,          32'h100);
      chk("drop_c13_valid", {31'd0, ifa.out_valid}, 32'd0);
      step();
      step();
      step(); // c16
      chk("drop_c16_valid", {31'd0, ifa.out_valid}, 32'd0);
      step(); // c17
      chk("drop_c17_valid", {31'd0, ifa.out_valid}, 32'd1);
      chk("drop_c17_pc",    ifa.out_pc,             32'h100);
      chk("drop_c17_ins",   ifa.out_instruction,    32'h40);

      // ---- redirect coinciding with ack and pop
      do_reset(0, 1'b1);
      step(); // c1
      step(); // c2
      step(); // c3
      step(); // c4
      chk("rd_c4_pc", ifa.out_pc, 32'h8);
      ifa.redirect    = 1'b1;
      ifa.redirect_pc = 32'h0000_0200;
      step(); // c5
      ifa.redirect = 1'b0;
      chk("rd_c5_valid", {31'd0, ifa.out_valid}, 32'd0);
      chk("rd_c5_addr",  ifa.imem_addr,          32'h200);
      step(); // c6
      chk("rd_c6_valid", {31'd0, ifa.out_valid}, 32'd1);
      chk("rd_c6_pc",    ifa.out_pc,             32'h200);
      chk("rd_c6_ins",   ifa.out_instruction,    32'h80);
      step(); // c7
      chk("rd_c7_pc",    ifa.out_pc,             32'h204);
      chk("rd_c7_ins",   ifa.out_instruction,    32'h81);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
